// File: rtl/tone_analyzer_pkg.sv
// tone_pkg: crossing-FSM state encoding and default tone levels shared by the analyzer blocks
package tone_pkg;
  localparam int TONE_MIDPOINT = 128;
  localparam int TONE_HYSTERESIS = 8;
  typedef enum logic [1:0] {SEEK_LOW = 2'd0, LOW = 2'd1, HIGH = 2'd2} tone_state_e;
endpackage

// File: rtl/tone_analyzer_if.sv
// tone_analyzer_if: sample stream in, period/peak measurement and status out
interface tone_analyzer_if #(
  parameter int PERIOD_W = 16
);
  logic                sample_valid;
  logic [8:0]          sample;
  logic [PERIOD_W-1:0] period;
  logic [8:0]          peak_max;
  logic [8:0]          peak_min;
  logic                result_valid;
  logic                locked;
  logic                no_signal;
  modport master (
    output sample_valid, sample,
    input  period, peak_max, peak_min, result_valid, locked, no_signal
  );
  modport slave (
    input  sample_valid, sample,
    output period, peak_max, peak_min, result_valid, locked, no_signal
  );
endinterface

// File: rtl/tone_crossing_detector.sv
// tone_crossing_detector: hysteresis threshold FSM; pulses rising_event_o on a valid low-to-high crossing
module tone_crossing_detector
  import tone_pkg::*;
#(
  parameter int MIDPOINT   = TONE_MIDPOINT,
  parameter int HYSTERESIS = TONE_HYSTERESIS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid_i,
  input  logic [8:0] sample_i,
  input  logic       clear_i,
  output logic       rising_event_o
);
  localparam logic [8:0] LO_TH = 9'(MIDPOINT - HYSTERESIS);
  localparam logic [8:0] HI_TH = 9'(MIDPOINT + HYSTERESIS);
  tone_state_e state_q, state_d;
  logic is_low, is_high;
  assign is_low = sample_i <= LO_TH;
  assign is_high = sample_i >= HI_TH;
  assign rising_event_o = sample_valid_i && state_q == LOW && is_high;
  // SEEK_LOW and HIGH both only react to a low sample, so they share one rule
  always_comb
    state_d = clear_i ? SEEK_LOW :
              !sample_valid_i ? state_q :
              rising_event_o ? HIGH :
              is_low ? LOW : state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= SEEK_LOW;
    else state_q <= state_d;
endmodule

// File: rtl/tone_analyzer.sv
// tone_analyzer: measures samples-per-cycle and peak levels of a tone between rising crossings
module tone_analyzer
  import tone_pkg::*;
#(
  parameter int MIDPOINT   = TONE_MIDPOINT,
  parameter int HYSTERESIS = TONE_HYSTERESIS,
  parameter int PERIOD_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_analyzer_if.slave bus
);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  logic                rising_event, timeout, advance, report;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [8:0]          run_max_q, run_max_d, run_min_q, run_min_d;
  logic [8:0]          peak_max_q, peak_max_d, peak_min_q, peak_min_d;
  logic                active_q, active_d, locked_q, locked_d;
  logic                no_signal_q, no_signal_d, result_valid_q, result_valid_d;
  tone_crossing_detector #(.MIDPOINT(MIDPOINT), .HYSTERESIS(HYSTERESIS)) u_det (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_valid_i (bus.sample_valid),
    .sample_i       (bus.sample),
    .clear_i        (timeout),
    .rising_event_o (rising_event)
  );
  // a saturated counter gives up unless this very sample is the crossing
  assign timeout = bus.sample_valid && active_q && !rising_event && cnt_q == CNT_MAX;
  assign advance = bus.sample_valid && active_q && !rising_event && !timeout;
  assign report = rising_event && active_q;
  always_comb begin
    cnt_d = rising_event ? PERIOD_W'(1) : advance ? cnt_q + PERIOD_W'(1) : cnt_q;
    run_max_d = rising_event ? bus.sample : advance && bus.sample > run_max_q ? bus.sample : run_max_q;
    run_min_d = rising_event ? bus.sample : advance && bus.sample < run_min_q ? bus.sample : run_min_q;
    period_d = report ? cnt_q : period_q;
    peak_max_d = report ? run_max_q : peak_max_q;
    peak_min_d = report ? run_min_q : peak_min_q;
    result_valid_d = report;
    active_d = rising_event ? 1'b1 : timeout ? 1'b0 : active_q;
    locked_d = report ? 1'b1 : timeout ? 1'b0 : locked_q;
    no_signal_d = report ? 1'b0 : timeout ? 1'b1 : no_signal_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q          <= '0;
      run_max_q      <= 9'd0;
      run_min_q      <= 9'd511;
      period_q       <= '0;
      peak_max_q     <= 9'd0;
      peak_min_q     <= 9'd0;
      result_valid_q <= 1'b0;
      active_q       <= 1'b0;
      locked_q       <= 1'b0;
      no_signal_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      run_max_q      <= run_max_d;
      run_min_q      <= run_min_d;
      period_q       <= period_d;
      peak_max_q     <= peak_max_d;
      peak_min_q     <= peak_min_d;
      result_valid_q <= result_valid_d;
      active_q       <= active_d;
      locked_q       <= locked_d;
      no_signal_q    <= no_signal_d;
    end
  assign bus.period = period_q;
  assign bus.peak_max = peak_max_q;
  assign bus.peak_min = peak_min_q;
  assign bus.result_valid = result_valid_q;
  assign bus.locked = locked_q;
  assign bus.no_signal = no_signal_q;
endmodule

// File: doc/tone_analyzer.md
TONE_ANALYZER -- requirements
Module: tone_analyzer

Interface
REQ-001 Parameter MIDPOINT, default 128: centre level of the incoming sample stream.
REQ-002 Parameter HYSTERESIS, default 8: crossing band half-width; low threshold is MIDPOINT-HYSTERESIS, high threshold is MIDPOINT+HYSTERESIS.
REQ-003 Parameter PERIOD_W, default 16: width of the period counter and the period output.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port sample_valid, input, 1: sample is present this cycle; no backpressure, every valid sample is consumed.
REQ-007 Port sample, input, 9: unsigned sample, nominal range 0..255.
REQ-008 Port period, output, PERIOD_W: samples per cycle of the last measured period.
REQ-009 Port peak_max, output, 9: largest sample in the last measured period.
REQ-010 Port peak_min, output, 9: smallest sample in the last measured period.
REQ-011 Port result_valid, output, 1: one-cycle pulse when period/peak_max/peak_min update.
REQ-012 Port locked, output, 1: at least one full period has been measured since reset or timeout.
REQ-013 Port no_signal, output, 1: sticky timeout flag.

Function
REQ-014 The crossing FSM SHALL have states SEEK_LOW, LOW and HIGH, and SHALL advance only on cycles with sample_valid=1.
REQ-015 In SEEK_LOW, sample <= low threshold SHALL move the FSM to LOW; other samples SHALL be ignored.
REQ-016 In LOW, sample >= high threshold SHALL be a rising event and SHALL move the FSM to HIGH.
REQ-017 In HIGH, sample <= low threshold SHALL move the FSM to LOW.
REQ-018 Samples strictly between the thresholds SHALL never change state.
REQ-019 A rising event SHALL load the counter with 1 and load running max/min with the event sample.
REQ-020 Each non-event valid sample after the first event SHALL increment the counter and update running max/min.
REQ-021 A rising event after the first SHALL register period=counter, peak_max=running max and peak_min=running min (event sample excluded), pulse result_valid on the next cycle, and set locked.
REQ-022 A square wave with events N samples apart SHALL therefore report period=N.
REQ-023 The first rising event after reset or timeout SHALL start measurement without pulsing result_valid.
REQ-024 If the counter equals 2^PERIOD_W-1 and the sample is not a rising event, the block SHALL set no_signal, clear locked, stop the counter and return to SEEK_LOW.
REQ-025 If a rising event coincides with counter saturation, the event SHALL take priority and report period=2^PERIOD_W-1.
REQ-026 no_signal SHALL clear on the next result_valid pulse.
REQ-027 Invalid cycles SHALL hold all state, counters and outputs, and result_valid SHALL be 0.
REQ-028 Comparisons and max/min SHALL be unsigned 9-bit.

Reset
REQ-029 rst_n=0 SHALL immediately force FSM=SEEK_LOW, counter=0, period=0, peak_max=0, peak_min=0, result_valid=0, locked=0, no_signal=0, running max=0 and running min=511.
REQ-030 Reset asserted mid-period SHALL discard the partial measurement.
REQ-031 After reset, the first measurement SHALL require a fresh SEEK_LOW -> LOW -> event sequence.

Structure
REQ-032 The FSM state encoding and the default MIDPOINT/HYSTERESIS constants SHALL live in the shared package tone_pkg.
REQ-033 The threshold FSM SHALL be a sub-module named tone_crossing_detector that outputs a one-cycle rising_event qualified by sample_valid.
REQ-034 Counter and peak tracking SHALL stay in tone_analyzer.

Verification
REQ-035 Continuous 32-point sine (128,152,...,255,...,0,...,103), valid every cycle -> first result after the second event; then result_valid every 32 cycles with period=32, peak_max=255, peak_min=0, locked=1.
REQ-036 Same sine with sample_valid asserted every other cycle -> period=32 and result_valid every 64 cycles.
REQ-037 Samples alternating 125/131 for 1000 cycles after reset -> no result_valid, FSM remains SEEK_LOW.
REQ-038 Square wave 0x5/255x5 -> period=10, peak_max=255, peak_min=0.
REQ-039 Lock on the sine, then hold sample=128 -> after 65535 counted samples no_signal=1 and locked=0; resuming the sine clears no_signal at the next result_valid.
REQ-040 Assert rst_n=0 at sine index 20 mid-period -> all outputs 0 at once; after release, the first result_valid appears only after two new rising events.
